// File: rtl/esteira_pkg.sv
// Shared definitions for the bottling conveyor: state encodings, box size and timer width.
// Also imported by the VGA display top, so keep the encodings stable.
package esteira_pkg;

    localparam int TIMER_W = 28;

    localparam logic [2:0] ST_PARADO   = 3'b000;
    localparam logic [2:0] ST_AG_ENCH  = 3'b001;
    localparam logic [2:0] ST_AG_VED   = 3'b010;
    localparam logic [2:0] ST_FALTA    = 3'b011;
    localparam logic [2:0] ST_AG_CQ    = 3'b100;
    localparam logic [2:0] ST_AG_LACRE = 3'b101;

    localparam logic [3:0] CAIXA_TAM = 4'd12;

    // True when the bottle about to be finished is the last one of the current box.
    function automatic logic fecha_caixa(input logic [3:0] box_cnt);
        return (box_cnt == (CAIXA_TAM - 4'd1));
    endfunction

endpackage

// File: rtl/timer_ciclos.sv
// Down-counting dwell/timeout timer: load a cycle count, count down while enabled.
// done is high when the current enabled cycle is the last one of the interval.
module timer_ciclos
    import esteira_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               enable,
    input  logic [TIMER_W-1:0] valor,
    output logic               done
);

    logic [TIMER_W-1:0] count_r;

    // Count register: load wins over counting, and the count holds at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {TIMER_W{1'b0}};
        end else if (load) begin
            count_r <= valor;
        end else if (enable && (count_r != {TIMER_W{1'b0}})) begin
            count_r <= count_r - {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r <= {{(TIMER_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/esteira_controller.sv
// Bottling conveyor controller: fill, cork, quality check, seal, with bottle/box counters.
// Optional build macro CQ_REJECT_EN: a failed quality check discards the bottle.
module esteira_controller
    import esteira_pkg::*;
#(
    parameter int FILL_TIMEOUT = 150_000_000,
    parameter int SEAL_CYCLES  = 50_000_000,
    parameter int ROLHA_MAX    = 15
) (
    input  logic       MAX10_CLK1_50,
    input  logic       reset,
    input  logic       ligar,
    input  logic       desligar,
    input  logic       repor_rolha,
    input  logic       sensor_enchimento,
    input  logic       sensor_cq,
    input  logic       sensor_lacre,
    input  logic       nivel_cheio,
    input  logic       cq_valid,
    input  logic       cq_ok,
    output logic [2:0] estado_atual,
    output logic       motor,
    output logic       val_enchimento,
    output logic       Motor_Parado_Pos_Enchimento,
    output logic       Motor_Parado_Pos_CQ,
    output logic       Motor_Parado_Pos_Lacre,
    output logic [3:0] rolhas,
    output logic [7:0] garrafas,
    output logic [7:0] caixas,
    output logic       descarte
);

    localparam logic [TIMER_W-1:0] FILL_LOAD  = TIMER_W'(FILL_TIMEOUT);
    localparam logic [TIMER_W-1:0] SEAL_LOAD  = TIMER_W'(SEAL_CYCLES);
    localparam logic [3:0]         ROLHA_LOAD = 4'(ROLHA_MAX);

    logic [2:0] state_r, state_s;
    logic       motor_r, motor_s;
    logic       valve_r, valve_s;
    logic       flag_ench_r, flag_ench_s;
    logic       flag_cq_r, flag_cq_s;
    logic       flag_lacre_r, flag_lacre_s;
    logic [3:0] rolhas_r, rolhas_s;
    logic [7:0] garrafas_r, garrafas_s;
    logic [7:0] caixas_r, caixas_s;
    logic [3:0] box_cnt_r, box_cnt_s;
    logic       descarte_r, descarte_s;

    logic               tmr_load_s;
    logic               tmr_en_s;
    logic [TIMER_W-1:0] tmr_value_s;
    logic               tmr_done_s;

    timer_ciclos u_timer (
        .clk    (MAX10_CLK1_50),
        .rst    (reset),
        .load   (tmr_load_s),
        .enable (tmr_en_s),
        .valor  (tmr_value_s),
        .done   (tmr_done_s)
    );

`ifndef CQ_REJECT_EN
    logic unused_cq_ok_s;
    assign unused_cq_ok_s = cq_ok;
`endif

    // Next-state, next-output and counter logic; motor_r/valve_r mark the sub-phase inside a station.
    always_comb begin
        state_s      = state_r;
        motor_s      = motor_r;
        valve_s      = valve_r;
        flag_ench_s  = flag_ench_r;
        flag_cq_s    = flag_cq_r;
        flag_lacre_s = flag_lacre_r;
        rolhas_s     = rolhas_r;
        garrafas_s   = garrafas_r;
        caixas_s     = caixas_r;
        box_cnt_s    = box_cnt_r;
        descarte_s   = 1'b0;
        tmr_load_s   = 1'b0;
        tmr_en_s     = 1'b0;
        tmr_value_s  = {TIMER_W{1'b0}};
        if (desligar) begin
            state_s      = ST_PARADO;
            motor_s      = 1'b0;
            valve_s      = 1'b0;
            flag_ench_s  = 1'b0;
            flag_cq_s    = 1'b0;
            flag_lacre_s = 1'b0;
            tmr_load_s   = 1'b1;
        end else begin
            case (state_r)
                ST_PARADO: begin
                    motor_s      = 1'b0;
                    valve_s      = 1'b0;
                    flag_ench_s  = 1'b0;
                    flag_cq_s    = 1'b0;
                    flag_lacre_s = 1'b0;
                    if (ligar) begin
                        state_s = ST_AG_ENCH;
                        motor_s = 1'b1;
                    end else begin
                        state_s = ST_PARADO;
                    end
                end
                ST_AG_ENCH: begin
                    if (motor_r) begin
                        if (sensor_enchimento) begin
                            motor_s     = 1'b0;
                            valve_s     = 1'b1;
                            flag_ench_s = 1'b1;
                            tmr_load_s  = 1'b1;
                            tmr_value_s = FILL_LOAD;
                        end else begin
                            motor_s = 1'b1;
                        end
                    end else if (valve_r) begin
                        tmr_en_s = 1'b1;
                        if (nivel_cheio || tmr_done_s) begin
                            valve_s     = 1'b0;
                            flag_ench_s = 1'b0;
                            tmr_load_s  = 1'b1;
                            tmr_value_s = SEAL_LOAD;
                            state_s     = (rolhas_r != 4'd0) ? ST_AG_VED : ST_FALTA;
                        end else begin
                            valve_s = 1'b1;
                        end
                    end else begin
                        motor_s     = 1'b1;
                        flag_ench_s = 1'b0;
                    end
                end
                ST_AG_VED: begin
                    motor_s  = 1'b0;
                    tmr_en_s = 1'b1;
                    if (tmr_done_s) begin
                        rolhas_s = (rolhas_r != 4'd0) ? (rolhas_r - 4'd1) : 4'd0;
                        state_s  = ST_AG_CQ;
                        motor_s  = 1'b1;
                    end else begin
                        state_s = ST_AG_VED;
                    end
                end
                ST_FALTA: begin
                    motor_s = 1'b0;
                    if (repor_rolha) begin
                        rolhas_s    = ROLHA_LOAD;
                        state_s     = ST_AG_VED;
                        tmr_load_s  = 1'b1;
                        tmr_value_s = SEAL_LOAD;
                    end else begin
                        state_s = ST_FALTA;
                    end
                end
                ST_AG_CQ: begin
                    if (motor_r) begin
                        if (sensor_cq) begin
                            motor_s   = 1'b0;
                            flag_cq_s = 1'b1;
                        end else begin
                            motor_s = 1'b1;
                        end
                    end else if (cq_valid) begin
                        flag_cq_s = 1'b0;
                        motor_s   = 1'b1;
`ifdef CQ_REJECT_EN
                        if (cq_ok) begin
                            state_s = ST_AG_LACRE;
                        end else begin
                            state_s    = ST_AG_ENCH;
                            descarte_s = 1'b1;
                        end
`else
                        state_s = ST_AG_LACRE;
`endif
                    end else begin
                        flag_cq_s = 1'b1;
                    end
                end
                ST_AG_LACRE: begin
                    if (motor_r) begin
                        if (sensor_lacre) begin
                            motor_s      = 1'b0;
                            flag_lacre_s = 1'b1;
                            tmr_load_s   = 1'b1;
                            tmr_value_s  = SEAL_LOAD;
                        end else begin
                            motor_s = 1'b1;
                        end
                    end else begin
                        tmr_en_s = 1'b1;
                        if (tmr_done_s) begin
                            flag_lacre_s = 1'b0;
                            motor_s      = 1'b1;
                            state_s      = ST_AG_ENCH;
                            garrafas_s   = garrafas_r + 8'd1;
                            // Box count runs on its own modulo-12 counter because garrafas wraps at 256.
                            if (fecha_caixa(box_cnt_r)) begin
                                box_cnt_s = 4'd0;
                                caixas_s  = caixas_r + 8'd1;
                            end else begin
                                box_cnt_s = box_cnt_r + 4'd1;
                            end
                        end else begin
                            flag_lacre_s = 1'b1;
                        end
                    end
                end
                default: begin
                    state_s      = ST_PARADO;
                    motor_s      = 1'b0;
                    valve_s      = 1'b0;
                    flag_ench_s  = 1'b0;
                    flag_cq_s    = 1'b0;
                    flag_lacre_s = 1'b0;
                end
            endcase
        end
    end

    // State, output and counter registers.
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            state_r      <= ST_PARADO;
            motor_r      <= 1'b0;
            valve_r      <= 1'b0;
            flag_ench_r  <= 1'b0;
            flag_cq_r    <= 1'b0;
            flag_lacre_r <= 1'b0;
            rolhas_r     <= ROLHA_LOAD;
            garrafas_r   <= 8'd0;
            caixas_r     <= 8'd0;
            box_cnt_r    <= 4'd0;
            descarte_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            motor_r      <= motor_s;
            valve_r      <= valve_s;
            flag_ench_r  <= flag_ench_s;
            flag_cq_r    <= flag_cq_s;
            flag_lacre_r <= flag_lacre_s;
            rolhas_r     <= rolhas_s;
            garrafas_r   <= garrafas_s;
            caixas_r     <= caixas_s;
            box_cnt_r    <= box_cnt_s;
            descarte_r   <= descarte_s;
        end
    end

    assign estado_atual                = state_r;
    assign motor                       = motor_r;
    assign val_enchimento              = valve_r;
    assign Motor_Parado_Pos_Enchimento = flag_ench_r;
    assign Motor_Parado_Pos_CQ         = flag_cq_r;
    assign Motor_Parado_Pos_Lacre      = flag_lacre_r;
    assign rolhas                      = rolhas_r;
    assign garrafas                    = garrafas_r;
    assign caixas                      = caixas_r;
    assign descarte                    = descarte_r;

endmodule

// File: tb/tb_esteira_controller.sv
// Self-checking bench for esteira_controller: directed scenarios plus randomized bottles
// checked against a counting model (total bottles, cork stock).
module tb_esteira_controller;

    localparam int FILL_T  = 20;
    localparam int SEAL_C  = 3;
    localparam int ROLHA_M = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       ligar, desligar, repor_rolha;
    logic       sensor_enchimento, sensor_cq, sensor_lacre, nivel_cheio;
    logic       cq_valid, cq_ok;
    logic [2:0] estado_atual;
    logic       motor, val_enchimento;
    logic       Motor_Parado_Pos_Enchimento, Motor_Parado_Pos_CQ, Motor_Parado_Pos_Lacre;
    logic [3:0] rolhas;
    logic [7:0] garrafas, caixas;
    logic       descarte;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int m_total  = 0;
    int m_rolhas = ROLHA_M;

    always #5 clk = ~clk;

    esteira_controller #(
        .FILL_TIMEOUT (FILL_T),
        .SEAL_CYCLES  (SEAL_C),
        .ROLHA_MAX    (ROLHA_M)
    ) dut (
        .MAX10_CLK1_50               (clk),
        .reset                       (reset),
        .ligar                       (ligar),
        .desligar                    (desligar),
        .repor_rolha                 (repor_rolha),
        .sensor_enchimento           (sensor_enchimento),
        .sensor_cq                   (sensor_cq),
        .sensor_lacre                (sensor_lacre),
        .nivel_cheio                 (nivel_cheio),
        .cq_valid                    (cq_valid),
        .cq_ok                       (cq_ok),
        .estado_atual                (estado_atual),
        .motor                       (motor),
        .val_enchimento              (val_enchimento),
        .Motor_Parado_Pos_Enchimento (Motor_Parado_Pos_Enchimento),
        .Motor_Parado_Pos_CQ         (Motor_Parado_Pos_CQ),
        .Motor_Parado_Pos_Lacre      (Motor_Parado_Pos_Lacre),
        .rolhas                      (rolhas),
        .garrafas                    (garrafas),
        .caixas                      (caixas),
        .descarte                    (descarte)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_garrafas"}, garrafas, m_total % 256);
        chk({tag, "_caixas"}, caixas, (m_total / 12) % 256);
        chk({tag, "_rolhas"}, rolhas, m_rolhas);
    endtask

    // Walks one bottle from "conveyor moving towards the filler" back to the same point.
    task automatic do_bottle(input int fill_len, input bit use_to, input bit ok, input bit abort_lacre);
        int n;
        wait_cycles($urandom_range(0, 3));
        chk("ench_move_state", estado_atual, 3'b001);
        chk("ench_move_motor", motor, 1);
        sensor_enchimento = 1'b1; tick(); sensor_enchimento = 1'b0;
        chk("fill_motor", motor, 0);
        chk("fill_valve", val_enchimento, 1);
        chk("fill_flag", Motor_Parado_Pos_Enchimento, 1);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (val_enchimento !== 1'b1) break;
            n++;
            nivel_cheio = (!use_to && n == fill_len);
            tick();
        end
        nivel_cheio = 1'b0;
        chk("valve_open_cycles", n, use_to ? FILL_T : fill_len);
        chk("post_fill_state", estado_atual, (m_rolhas > 0) ? 3'b010 : 3'b011);
        chk("post_fill_motor", motor, 0);
        chk("post_fill_flag", Motor_Parado_Pos_Enchimento, 0);
        if (m_rolhas == 0) begin
            wait_cycles($urandom_range(0, 2));
            chk("falta_state", estado_atual, 3'b011);
            chk("falta_motor", motor, 0);
            repor_rolha = 1'b1; tick(); repor_rolha = 1'b0;
            m_rolhas = ROLHA_M;
            chk("refill_rolhas", rolhas, 15);
            chk("refill_state", estado_atual, 3'b010);
        end
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (estado_atual !== 3'b010) break;
            n++;
            tick();
        end
        m_rolhas--;
        chk("seal_cycles", n, SEAL_C);
        chk("cq_move_state", estado_atual, 3'b100);
        chk("cq_move_motor", motor, 1);
        chk("seal_rolhas", rolhas, m_rolhas);
        wait_cycles($urandom_range(0, 3));
        sensor_cq = 1'b1; tick(); sensor_cq = 1'b0;
        chk("cq_stop_motor", motor, 0);
        chk("cq_stop_flag", Motor_Parado_Pos_CQ, 1);
        wait_cycles($urandom_range(0, 2));
        chk("cq_hold_state", estado_atual, 3'b100);
        cq_valid = 1'b1; cq_ok = ok; tick(); cq_valid = 1'b0; cq_ok = 1'b0;
        chk("cq_done_flag", Motor_Parado_Pos_CQ, 0);
        chk("cq_done_motor", motor, 1);
`ifdef CQ_REJECT_EN
        if (!ok) begin
            chk("reject_state", estado_atual, 3'b001);
            chk("reject_pulse", descarte, 1);
            tick();
            chk("reject_pulse_end", descarte, 0);
            chk_counters("reject");
            return;
        end
`endif
        chk("lacre_move_state", estado_atual, 3'b101);
        chk("descarte_low", descarte, 0);
        wait_cycles($urandom_range(0, 3));
        sensor_lacre = 1'b1; tick(); sensor_lacre = 1'b0;
        chk("lacre_stop_motor", motor, 0);
        chk("lacre_stop_flag", Motor_Parado_Pos_Lacre, 1);
        if (abort_lacre) begin
            desligar = 1'b1; tick(); desligar = 1'b0;
            chk("abort_state", estado_atual, 3'b000);
            chk("abort_motor", motor, 0);
            chk("abort_flag", Motor_Parado_Pos_Lacre, 0);
            chk_counters("abort");
            ligar = 1'b1; tick(); ligar = 1'b0;
            chk("restart_state", estado_atual, 3'b001);
            return;
        end
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (Motor_Parado_Pos_Lacre !== 1'b1) break;
            n++;
            tick();
        end
        m_total++;
        chk("lacre_cycles", n, SEAL_C);
        chk("finish_state", estado_atual, 3'b001);
        chk("finish_motor", motor, 1);
        chk_counters("finish");
    endtask

    initial begin
        #900_000;
        $error("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int guard;
        reset = 1'b1; ligar = 1'b0; desligar = 1'b0; repor_rolha = 1'b0;
        sensor_enchimento = 1'b0; sensor_cq = 1'b0; sensor_lacre = 1'b0;
        nivel_cheio = 1'b0; cq_valid = 1'b0; cq_ok = 1'b0;
        wait_cycles(3);
        chk("rst_state", estado_atual, 3'b000);
        chk("rst_motor", motor, 0);
        chk("rst_valve", val_enchimento, 0);
        chk("rst_flags", {Motor_Parado_Pos_Enchimento, Motor_Parado_Pos_CQ, Motor_Parado_Pos_Lacre}, 0);
        chk("rst_descarte", descarte, 0);
        chk_counters("rst");
        reset = 1'b0; tick();
        ligar = 1'b1; desligar = 1'b1; tick(); ligar = 1'b0; desligar = 1'b0;
        chk("ligar_desligar_state", estado_atual, 3'b000);
        chk("ligar_desligar_motor", motor, 0);
        ligar = 1'b1; tick(); ligar = 1'b0;
        chk("start_state", estado_atual, 3'b001);
        chk("start_motor", motor, 1);
        ligar = 1'b1; tick(); ligar = 1'b0;
        chk("ligar_ignored", estado_atual, 3'b001);

        do_bottle(10, 1'b0, 1'b1, 1'b0);
        do_bottle(0, 1'b1, 1'b1, 1'b0);
        do_bottle(3, 1'b0, 1'b0, 1'b0);
        do_bottle(4, 1'b0, 1'b1, 1'b1);

        guard = 0;
        while (m_total < 256 && guard < 600) begin
            do_bottle($urandom_range(1, 15), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 4) != 0), 1'b0);
            guard++;
        end
        chk("wrap_garrafas", garrafas, 0);
        chk("wrap_caixas", caixas, 21);

        reset = 1'b1; #1;
        chk("async_rst_state", estado_atual, 3'b000);
        chk("async_rst_motor", motor, 0);
        chk("async_rst_rolhas", rolhas, 15);
        chk("async_rst_caixas", caixas, 0);
        tick(); reset = 1'b0; tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/esteira_controller.md
ESTEIRA_CONTROLLER -- requirements
Module: esteira_controller

Interface
REQ-001 Parameter FILL_TIMEOUT, default 150_000_000, is the maximum valve-open cycles before forced close.
REQ-002 Parameter SEAL_CYCLES, default 50_000_000, is the cork-insertion and lacre dwell time in cycles.
REQ-003 Parameter ROLHA_MAX, default 15, is the cork reload value; 4-bit range.
REQ-004 Port MAX10_CLK1_50  in  1  is the single system clock.
REQ-005 Port reset  in  1  is the asynchronous, active-high reset.
REQ-006 Ports ligar, desligar, repor_rolha  in  1 each  are single-cycle command pulses: start, stop, cork refill.
REQ-007 Ports sensor_enchimento, sensor_cq, sensor_lacre  in  1 each  are bottle-present-at-station sensors.
REQ-008 Port nivel_cheio  in  1  is the fill-level-reached sensor.
REQ-009 Ports cq_valid, cq_ok  in  1 each  form the quality-check result strobe and verdict.
REQ-010 Port estado_atual  out  3  is the current state, encoded per REQ-013.
REQ-011 Ports motor, val_enchimento, Motor_Parado_Pos_Enchimento, Motor_Parado_Pos_CQ, Motor_Parado_Pos_Lacre  out  1 each  drive the conveyor, the valve and the station-stop flags.
REQ-012 Ports rolhas (4), garrafas (8), caixas (8), descarte (1)  out  give the cork stock, finished bottles, completed boxes of 12 and the reject pulse.

Function
REQ-013 Encoding SHALL be: PARADO 000, AGUARDANDO_ENCHIMENTO 001, AGUARDANDO_VEDACAO 010, FALTA_ROLHA 011, AGUARDANDO_CQ 100, AGUARDANDO_LACRE 101; 110 and 111 go to PARADO on the next edge.
REQ-014 All outputs SHALL be registered and take effect on the edge after the causing input.
REQ-015 PARADO: motor=0, all flags 0; ligar moves the block to AGUARDANDO_ENCHIMENTO.
REQ-016 AGUARDANDO_ENCHIMENTO: motor=1 until sensor_enchimento=1.
REQ-017 At that point motor=0, Motor_Parado_Pos_Enchimento=1 and val_enchimento=1.
REQ-018 The valve closes on nivel_cheio=1 or after FILL_TIMEOUT cycles, whichever comes first.
REQ-019 After the valve closes, the next state is AGUARDANDO_VEDACAO if rolhas>0, otherwise FALTA_ROLHA.
REQ-020 AGUARDANDO_VEDACAO: motor=0 for SEAL_CYCLES, then rolhas decrements by 1 and the next state is AGUARDANDO_CQ.
REQ-021 FALTA_ROLHA: motor=0; repor_rolha loads rolhas=ROLHA_MAX and moves the block to AGUARDANDO_VEDACAO.
REQ-022 AGUARDANDO_CQ: motor=1 until sensor_cq=1, then motor=0 and Motor_Parado_Pos_CQ=1.
REQ-023 In AGUARDANDO_CQ, cq_valid=1 with cq_ok=1 moves the block to AGUARDANDO_LACRE.
REQ-024 AGUARDANDO_LACRE: motor=1 until sensor_lacre=1, then motor=0 and Motor_Parado_Pos_Lacre=1 for SEAL_CYCLES.
REQ-025 At the end of the lacre dwell, garrafas increments and the next state is AGUARDANDO_ENCHIMENTO.
REQ-026 Every 12th finished bottle SHALL increment caixas; garrafas and caixas wrap 255->0.
REQ-027 desligar SHALL force PARADO from any state on the next edge, clearing motor, the valve and all flags.
REQ-028 desligar SHALL preserve rolhas, garrafas and caixas and SHALL reset the dwell timer.
REQ-029 ligar together with desligar SHALL yield PARADO; ligar outside PARADO is ignored.
REQ-030 At most one Motor_Parado_Pos_* flag SHALL be high, and only while motor=0.

Reset
REQ-031 Reset SHALL force PARADO, all 1-bit outputs 0, rolhas=ROLHA_MAX, garrafas=0, caixas=0, timer=0, asynchronously.

Configuration
REQ-032 With CQ_REJECT_EN defined, cq_valid with cq_ok=0 SHALL pulse descarte for 1 cycle and return to AGUARDANDO_ENCHIMENTO without counting the bottle.
REQ-033 Without CQ_REJECT_EN, cq_valid alone SHALL pass the bottle, and descarte SHALL be tied to 0.

Structure
REQ-034 State encodings and the box size (12) SHALL live in shared package esteira_pkg, also used by the VGA top.
REQ-035 Dwell and timeout counting SHALL use one sub-module, timer_ciclos: load, enable and done, 28-bit.

Verification
REQ-036 ligar, sensor_enchimento, nivel_cheio 10 cycles later -> val_enchimento high exactly 10 cycles, then estado_atual=010.
REQ-037 nivel_cheio never asserted, FILL_TIMEOUT=20 -> valve closes after 20 cycles, then state 010.
REQ-038 rolhas=0 after fill -> state 011, motor=0; repor_rolha -> rolhas=15, state 010.
REQ-039 Full cycle repeated 12 times -> garrafas=12, caixas=1; a 256th bottle -> garrafas=0.
REQ-040 CQ_REJECT_EN with cq_ok=0 -> descarte 1-cycle pulse, garrafas unchanged; desligar mid-lacre -> PARADO, counters kept.
